// File: rtl/pbkdf2_pkg.sv
// Shared definitions for the PBKDF2-HMAC-SHA512 iteration controller.
//   state_e        : controller FSM states
//   HMAC_MODE_*    : hmac core message-length select values
//   *_W            : datapath widths
package pbkdf2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic HMAC_MODE_36B = 1'b0;
  localparam logic HMAC_MODE_64B = 1'b1;

  localparam int unsigned KEY_W  = 1024;
  localparam int unsigned SALT_W = 256;
  localparam int unsigned BLK_W  = 512;
  localparam int unsigned IDX_W  = 32;

endpackage

// File: rtl/pbkdf2_ctrl.sv
// PBKDF2-HMAC-SHA512 iteration controller. Drives one external hmac core
// cmax times: the first call hashes salt||block_idx, each later call hashes
// the previous HMAC output, and all outputs are XOR-accumulated into dk.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : request, accepted in IDLE or DONE
//   iterations       : iteration count c (0 treated as 1)
//   key/salt/block_idx : request inputs, captured on accept
//   busy, done, dk   : status and derived block T (valid while done)
//   hmac_*           : direct connection to the hmac core
module pbkdf2_ctrl
  import pbkdf2_pkg::*;
#(
  parameter int unsigned ITER_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iterations,
  input  logic [KEY_W-1:0]  key,
  input  logic [SALT_W-1:0] salt,
  input  logic [IDX_W-1:0]  block_idx,
  output logic              busy,
  output logic              done,
  output logic [BLK_W-1:0]  dk,
  output logic              hmac_reset,
  output logic              hmac_mode,
  output logic [KEY_W-1:0]  hmac_key,
  output logic [BLK_W-1:0]  hmac_msg,
  input  logic              hmac_done,
  input  logic [BLK_W-1:0]  hmac_out
);

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d, cmax_q, cmax_d, cnt_inc;
  logic [BLK_W-1:0]    dk_q, dk_d, msg_q, msg_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                mode_q, mode_d;
  logic                hrst_q, hrst_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                accept;

  // cnt never exceeds cmax-1 before increment, so this cannot wrap
  assign cnt_inc = cnt_q + 1'b1;
  assign accept  = ((state_q == IDLE) || (state_q == DONE)) && start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = LAUNCH;
      LAUNCH:     state_d = WAIT;
      WAIT: begin
        if (hmac_done) state_d = (cnt_inc == cmax_q) ? DONE : LAUNCH;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Every output is computed one cycle ahead
  // from state_d so that it comes straight from a flop. The message register
  // doubles as the salt||index capture (only needed by the first launch) and
  // as U_prev, since every later launch sends exactly the last hmac_out.
  always_comb begin
    cnt_d  = cnt_q;
    cmax_d = cmax_q;
    dk_d   = dk_q;
    msg_d  = msg_q;
    mode_d = mode_q;
    key_d  = key_q;
    hrst_d = (state_d == WAIT);
    busy_d = (state_d == LAUNCH) || (state_d == WAIT);
    done_d = (state_d == DONE);
    if (accept) begin
      key_d  = key;
      cmax_d = (iterations == '0) ? ITER_W'(1) : iterations;
      cnt_d  = '0;
      mode_d = HMAC_MODE_36B;
      msg_d  = {salt, block_idx, {(BLK_W - SALT_W - IDX_W){1'b0}}};
    end else if ((state_q == WAIT) && hmac_done) begin
      dk_d   = (cnt_q == '0) ? hmac_out : (dk_q ^ hmac_out);
      cnt_d  = cnt_inc;
      msg_d  = hmac_out;
      mode_d = HMAC_MODE_64B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      cmax_q <= '0;
      dk_q   <= '0;
      msg_q  <= '0;
      mode_q <= 1'b0;
      key_q  <= '0;
      hrst_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmax_q <= cmax_d;
      dk_q   <= dk_d;
      msg_q  <= msg_d;
      mode_q <= mode_d;
      key_q  <= key_d;
      hrst_q <= hrst_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dk         = dk_q;
  assign hmac_reset = hrst_q;
  assign hmac_mode  = mode_q;
  assign hmac_key   = key_q;
  assign hmac_msg   = msg_q;

endmodule

// File: doc/pbkdf2_ctrl.md
# pbkdf2_ctrl

Iteration controller that runs the existing `hmac` core repeatedly to compute one PBKDF2-HMAC-SHA512 output block. The first call hashes salt‖block index; each later call hashes the previous HMAC output; all outputs are XOR-accumulated. It sits between the key-derivation requester and one `hmac` instance that the parent instantiates beside it. The `hmac` core's ports connect directly to this block's `hmac_*` ports.

## Interface
- `ITER_W`, default 32: width of the iteration count and the internal counter.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request. Accepted only in IDLE or DONE.
- `iterations` in ITER_W: PBKDF2 iteration count c. A value of 0 is treated as 1.
- `key` in 1024: zero-padded HMAC key.
- `salt` in 256: 32-byte salt, byte 0 in bits [255:248].
- `block_idx` in 32: PBKDF2 block index INT(i), big-endian.
- `busy` out 1: high in LAUNCH and WAIT.
- `done` out 1: high in DONE.
- `dk` out 512: derived block T. Valid while `done` is high.
- `hmac_reset` out 1: drives the core's active-low reset. Registered.
- `hmac_mode` out 1: 0 selects a 36-byte message; 1 selects a 64-byte message.
- `hmac_key` out 1024: captured key.
- `hmac_msg` out 512: message to the core.
- `hmac_done` in 1: core done. A level, held until the core is reset.
- `hmac_out` in 512: core result, U_j.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE, with `start`: capture `key`, `salt`, `block_idx`, and `cmax = (iterations==0) ? 1 : iterations`. Clear `cnt` to 0. Go to LAUNCH.
- LAUNCH, one cycle: `hmac_reset`=0.
  - If `cnt`==0: `hmac_mode`=0, `hmac_msg` = {salt, block_idx, 224'b0}. The message occupies bits [511:224].
  - Otherwise: `hmac_mode`=1, `hmac_msg` = U_prev, the last captured `hmac_out`.
  - Go to WAIT.
- WAIT: `hmac_reset`=1, and `hmac_mode`/`hmac_msg` are held stable. When `hmac_done`=1:
  - U_prev ← `hmac_out`.
  - `dk` ← `hmac_out` if `cnt`==0, otherwise `dk ^ hmac_out`.
  - `cnt` ← `cnt`+1.
  - If `cnt`+1 == `cmax`, go to DONE; otherwise go to LAUNCH.
- DONE: `done`=1 and `dk` is held.
  - `start` here behaves as in IDLE: re-capture the inputs and go to LAUNCH, with `done` falling in that same transition.
  - With no `start`, stay in DONE.
- `start` in LAUNCH or WAIT is ignored. The captured inputs do not change.
- `hmac_reset`=0 in IDLE, LAUNCH and DONE, so the core is held in reset whenever it is unused.
- `hmac_done` is ignored outside WAIT.
- Counter: `cnt` is ITER_W bits and never wraps, because it stops at `cmax`. `cmax` = 2^ITER_W−1 is legal.
- Reset (any state, including mid-WAIT): next state IDLE; `busy`=0, `done`=0, `dk`=0, `hmac_reset`=0, `hmac_mode`=0, `hmac_msg`=0, `hmac_key`=0, `cnt`=0, U_prev=0. The core is therefore reset on the cycle after `reset` is sampled, discarding any partial hash.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE or DONE.
- H is the number of WAIT cycles up to and including the cycle in which `hmac_done` is sampled high. H ≥ 1.
- Iteration j (j = 1..cmax) occupies cycles (j−1)(1+H)+1 through j(1+H). Its LAUNCH is the first of these cycles.
- `done` rises at cycle cmax·(1+H)+1.
- `busy` is high from cycle 1 through cycle cmax·(1+H).
- All outputs are registered. There is no combinational path from `hmac_done` or `start` to any output.

## Structure
- Package `pbkdf2_pkg` holds:
  - the state enum (IDLE, LAUNCH, WAIT, DONE);
  - `HMAC_MODE_36B`=0 and `HMAC_MODE_64B`=1;
  - width localparams: KEY_W=1024, SALT_W=256, BLK_W=512.
- No sub-module. The `hmac` core is instantiated by the parent and connected via the `hmac_*` ports.
- The counter, accumulator and capture registers are inline.

## Test plan
Benches use the real `hmac` core, or a stub with fixed H=5 and `hmac_out` = msg ^ {16{32'hA5A5A5A5}}, plus a software PBKDF2-HMAC-SHA512 model.

- iterations=3, stub core, salt=256'h01…20, block_idx=1 → `done` rises at cycle 19. `hmac_mode` sequence is 0,1,1. The second `hmac_msg` equals the first `hmac_out`. `dk` equals the model's U1^U2^U3.
- iterations=0 → identical to iterations=1: `done` at cycle 7, `dk` = U1, exactly one LAUNCH.
- Real core, key="password" zero-padded, salt=32×8'h73, block_idx=1, iterations=2 → `dk` matches the software PBKDF2 block 1.
- `start` pulsed in WAIT with different `salt` and `iterations` → ignored. The result and timing equal the first request's.
- `reset` asserted mid-WAIT of iteration 2 → next cycle all outputs are 0 and `hmac_reset`=0. A subsequent `start` with iterations=1 gives a correct `dk` at cycle 7.
- `start` held high in DONE → `done` drops the next cycle and the new request completes with correct timing. No extra cycle is spent in IDLE.
